ultrasonic_ranger: RTL and testbench

ULTRASONIC_RANGER -- requirements
Module: ultrasonic_ranger

---
 rtl/ultrasonic_ranger.sv | 189 ++++++++++++++++++
 tb/tb_ultrasonic_ranger.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ultrasonic_ranger.sv
// Ultrasonic ranger: periodic trigger pulse, echo-width measurement in cm,
// timeout detection. Time base is a free-running 1 us prescaler tick.
module ultrasonic_ranger #(
  parameter int CLK_DIV    = 50,
  parameter int TRIG_US    = 10,
  parameter int PERIOD_US  = 60000,
  parameter int TIMEOUT_US = 30000,
  parameter int US_PER_CM  = 58
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       echo,
  output logic       trig,
  output logic [9:0] distance,
  output logic       dist_valid,
  output logic       timeout
);

  localparam int PRE_W = $clog2(CLK_DIV + 1);
  localparam int PER_W = $clog2(PERIOD_US + 1);
  localparam int TRG_W = $clog2(TRIG_US + 1);
  localparam int TMO_W = $clog2(TIMEOUT_US + 1);
  localparam int SUB_W = $clog2(US_PER_CM + 1);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
  localparam logic [PER_W-1:0] PER_MAX  = PER_W'(PERIOD_US);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD_US - 1);
  localparam logic [TRG_W-1:0] TRG_LAST = TRG_W'(TRIG_US - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_US);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_US - 1);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(US_PER_CM - 1);
  localparam logic [9:0]       CM_MAX   = 10'd1023;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_ECHO = 3'd2,
    MEASURE   = 3'd3,
    DONE      = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [PER_W-1:0] per_q, per_d;
  logic [TRG_W-1:0] trg_q, trg_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [SUB_W-1:0] sub_q, sub_d;
  logic [9:0]       cm_q, cm_d;
  logic             to_flag_q, to_flag_d;
  logic [2:0]       sync_q, sync_d;
  logic             trig_q, trig_d;
  logic [9:0]       distance_q, distance_d;
  logic             dist_valid_q, dist_valid_d;
  logic             timeout_q, timeout_d;

  logic us_tick, per_done, tmo_exp, echo_rise, echo_fall;

  // sync_q[1] is the synchronized echo, sync_q[2] its previous value
  always_comb begin
    sync_d    = {sync_q[1:0], echo};
    echo_rise = sync_q[1] & ~sync_q[2];
    echo_fall = ~sync_q[1] & sync_q[2];
    us_tick   = (pre_q == PRE_LAST);
    pre_d     = us_tick ? '0 : pre_q + 1'b1;
  end

  // A saturated period counter lets a late en trigger on the next IDLE cycle;
  // otherwise the trigger lands on the PERIOD_US-th tick since the last one.
  always_comb begin
    per_done = (per_q == PER_MAX) || (us_tick && per_q == PER_LAST);
    tmo_exp  = us_tick && (tmo_q == TMO_LAST);
  end

  always_comb begin
    state_d      = state_q;
    per_d        = per_q;
    trg_d        = trg_q;
    tmo_d        = tmo_q;
    sub_d        = sub_q;
    cm_d         = cm_q;
    to_flag_d    = to_flag_q;
    trig_d       = trig_q;
    distance_d   = distance_q;
    timeout_d    = timeout_q;
    dist_valid_d = 1'b0;

    if (us_tick && per_q != PER_MAX) per_d = per_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (per_done && en) begin
          per_d     = '0;
          trg_d     = '0;
          to_flag_d = 1'b0;
          trig_d    = 1'b1;
          state_d   = TRIG;
        end
      end
      TRIG: begin
        if (us_tick) begin
          if (trg_q == TRG_LAST) begin
            trig_d  = 1'b0;
            tmo_d   = '0;
            state_d = WAIT_ECHO;
          end else begin
            trg_d = trg_q + 1'b1;
          end
        end
      end
      WAIT_ECHO: begin
        if (us_tick && tmo_q != TMO_MAX) tmo_d = tmo_q + 1'b1;
        if (tmo_exp) begin
          to_flag_d = 1'b1;
          state_d   = DONE;
        end else if (echo_rise) begin
          cm_d    = '0;
          sub_d   = '0;
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (us_tick && tmo_q != TMO_MAX) tmo_d = tmo_q + 1'b1;
        // The tick in the falling-edge cycle still counts, so MEASURE covers
        // exactly the echo width regardless of prescaler phase.
        if (us_tick) begin
          if (sub_q == SUB_LAST) begin
            sub_d = '0;
            if (cm_q != CM_MAX) cm_d = cm_q + 1'b1;
          end else begin
            sub_d = sub_q + 1'b1;
          end
        end
        if (echo_fall) begin
          to_flag_d = 1'b0;
          state_d   = DONE;
        end else if (tmo_exp) begin
          to_flag_d = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        distance_d   = to_flag_q ? CM_MAX : cm_q;
        timeout_d    = to_flag_q;
        dist_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pre_q        <= '0;
      per_q        <= '0;
      trg_q        <= '0;
      tmo_q        <= '0;
      sub_q        <= '0;
      cm_q         <= '0;
      to_flag_q    <= 1'b0;
      sync_q       <= '0;
      trig_q       <= 1'b0;
      distance_q   <= '0;
      dist_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_q        <= pre_d;
      per_q        <= per_d;
      trg_q        <= trg_d;
      tmo_q        <= tmo_d;
      sub_q        <= sub_d;
      cm_q         <= cm_d;
      to_flag_q    <= to_flag_d;
      sync_q       <= sync_d;
      trig_q       <= trig_d;
      distance_q   <= distance_d;
      dist_valid_q <= dist_valid_d;
      timeout_q    <= timeout_d;
    end
  end

  assign trig       = trig_q;
  assign distance   = distance_q;
  assign dist_valid = dist_valid_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Scoreboard bench for ultrasonic_ranger on scaled-down timing parameters;
// expected ranges come from echo width in us divided by us-per-cm.
module tb_ultrasonic_ranger;

  localparam int CLK_DIV    = 2;
  localparam int TRIG_US    = 5;
  localparam int PERIOD_US  = 1500;
  localparam int TIMEOUT_US = 800;
  localparam int US_PER_CM  = 6;
  localparam int PER_CLK    = PERIOD_US * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       echo = 1'b0;
  logic       trig;
  logic [9:0] distance;
  logic       dist_valid;
  logic       timeout;

  ultrasonic_ranger #(
    .CLK_DIV(CLK_DIV), .TRIG_US(TRIG_US), .PERIOD_US(PERIOD_US),
    .TIMEOUT_US(TIMEOUT_US), .US_PER_CM(US_PER_CM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .echo(echo), .trig(trig),
    .distance(distance), .dist_valid(dist_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] d;
    logic       t;
  } exp_t;

  exp_t   sb[$];
  int     errors = 0;
  int     checks = 0;
  longint cyc = 0;
  longint last_rise = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_trig(input logic lvl, input int budget, output bit ok, output int n);
    n = 0;
    while (trig !== lvl && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    ok = (trig === lvl);
  endtask

  // Reference: range = floor(echo_us / US_PER_CM) capped at 1023,
  // or 1023 with timeout set when the echo never completes in time.
  function automatic exp_t model(input int kind, input int hi_us);
    exp_t e;
    if (kind == 0) begin
      e.d = 10'((hi_us / US_PER_CM > 1023) ? 1023 : hi_us / US_PER_CM);
      e.t = 1'b0;
    end else begin
      e.d = 10'd1023;
      e.t = 1'b1;
    end
    return e;
  endfunction

  // kind: 0 = echo pulse, 1 = no echo, 2 = echo stuck high from before trigger
  task automatic meas(input int kind, input int dly_us, input int hi_us,
                      input string pname, input bit en_off);
    bit     ok;
    int     n;
    longint rise_c;
    if (kind == 2) echo = 1'b1;
    wait_trig(1'b1, PER_CLK + 100, ok, n);
    if (!ok) begin
      chk({pname, "_rise_wait"}, 0, 1);
      return;
    end
    if (last_rise >= 0) chk(pname, cyc - last_rise, PER_CLK);
    last_rise = cyc;
    rise_c = cyc;
    wait_trig(1'b0, TRIG_US * CLK_DIV + 100, ok, n);
    chk("trig_width", cyc - rise_c, TRIG_US * CLK_DIV);
    if (en_off) en = 1'b0;
    sb.push_back(model(kind, hi_us));
    if (kind == 0) begin
      tick(dly_us * CLK_DIV);
      echo = 1'b1;
      tick(hi_us * CLK_DIV);
      echo = 1'b0;
      tick(10);
    end else begin
      tick(TIMEOUT_US * CLK_DIV + 10);
      echo = 1'b0;
    end
  endtask

  initial begin
    bit ok;
    int n;
    int rises;

    fork
      forever begin
        exp_t e;
        @(posedge clk);
        #1;
        if (rst_n === 1'b1 && dist_valid === 1'b1) begin
          if (sb.size() == 0) begin
            chk("unexpected_dist_valid", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("distance", distance, e.d);
            chk("timeout_flag", timeout, e.t);
          end
        end
      end
    join_none

    tick(3);
    chk("rst_trig", trig, 0);
    chk("rst_distance", distance, 0);
    chk("rst_dist_valid", dist_valid, 0);
    chk("rst_timeout", timeout, 0);
    rst_n = 1'b1;
    en    = 1'b1;
    last_rise = cyc;

    meas(0, 200, 20 * US_PER_CM, "first_trig_after_reset", 1'b0);
    meas(0, 200, 60 * US_PER_CM, "trig_period", 1'b0);
    meas(0, 200, 60 * US_PER_CM - 1, "trig_period", 1'b0);
    meas(1, 0, 0, "trig_period", 1'b0);
    meas(0, 50, 17 * US_PER_CM + 3, "trig_period", 1'b0);
    meas(2, 0, 0, "trig_period", 1'b0);
    meas(0, 30, 5, "trig_period", 1'b0);
    for (int i = 0; i < 6; i++) begin
      int d;
      int h;
      d = $urandom_range(100, 1);
      h = $urandom_range(TIMEOUT_US - d - 10, 1);
      meas(0, d, h, "trig_period", 1'b0);
    end

    // en dropped mid-measurement: result still delivered, then no more triggers
    meas(0, 40, 33 * US_PER_CM, "trig_period", 1'b1);
    rises = 0;
    for (int i = 0; i < 2 * PER_CLK; i++) begin
      tick(1);
      if (trig === 1'b1) rises++;
    end
    chk("no_trig_while_en0", rises, 0);
    en = 1'b1;
    wait_trig(1'b1, 3, ok, n);
    chk("trig_after_en", n, 1);

    // reset in the middle of MEASURE discards the measurement
    wait_trig(1'b0, PER_CLK, ok, n);
    chk("trig_fall_before_reset", ok, 1);
    tick(50 * CLK_DIV);
    echo = 1'b1;
    tick(100 * CLK_DIV);
    rst_n = 1'b0;
    #2;
    chk("midrst_trig", trig, 0);
    chk("midrst_distance", distance, 0);
    chk("midrst_dist_valid", dist_valid, 0);
    chk("midrst_timeout", timeout, 0);
    tick(3);
    echo  = 1'b0;
    rst_n = 1'b1;
    last_rise = cyc;
    meas(0, 80, 44 * US_PER_CM + 2, "trig_after_reset_release", 1'b0);

    tick(20);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
